ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the counterpart of the keyboard receive/decode path.
- Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard using the PS/2 host request-to-send sequence, and checks the device ACK bit.
- Drives the shared open-drain PS2_CLK/PS2_DATA lines through output-enable pins; the top-level tristate ties the lines low when the enable is set.
- Asserts busy so the receive path can ignore line activity during a transmit.

---
 rtl/ps2_host_tx_if.sv | 21 ++
 rtl/ps2_host_tx.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Byte-level request/status bundle between a PS/2 command source and the
// host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ACK check and watchdog.
// Optional PS2_CLK glitch filter: define PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst,
  ps2_host_tx_if.slave tx,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic ps2_clk_oe,
  output logic ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, DATA, ACK_WAIT
  } state_t;

  state_t state, state_n;

  logic [1:0] clk_sync, data_sync;
  logic       clk_s, data_s;
  logic       clk_f, clk_prev, fall;

  logic [7:0]    data_q, data_n;
  logic          par_q, par_n;
  logic [3:0]    bit_cnt, cnt_n;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [TW-1:0] wd_cnt, wd_n;
  logic          dbit_q, dbit_n;
  logic          done_q, done_n;
  logic          err_q, err_n;
  logic [1:0]    code_q, code_n;
  logic          wd_tick, wd_hit, inh_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  logic [FW-1:0] f_cnt;

  // Level flips only after FILTER_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_f <= 1'b1;
      f_cnt <= '0;
    end else if (clk_s == clk_f) begin
      f_cnt <= '0;
    end else if (f_cnt == FW'(FILTER_CYCLES - 1)) begin
      clk_f <= clk_s;
      f_cnt <= '0;
    end else begin
      f_cnt <= f_cnt + 1'b1;
    end
  end
`else
  logic unused_filter;
  assign unused_filter = |FILTER_CYCLES;
  assign clk_f = clk_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_prev <= 1'b1;
    else     clk_prev <= clk_f;
  end

  assign fall     = clk_prev & ~clk_f;
  assign wd_hit   = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign inh_last = (inh_cnt == IW'(INHIBIT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
      inh_cnt <= '0;
      wd_cnt  <= '0;
      dbit_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state   <= state_n;
      data_q  <= data_n;
      par_q   <= par_n;
      bit_cnt <= cnt_n;
      inh_cnt <= inh_n;
      wd_cnt  <= wd_n;
      dbit_q  <= dbit_n;
      done_q  <= done_n;
      err_q   <= err_n;
      code_q  <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data_q;
    par_n   = par_q;
    cnt_n   = bit_cnt;
    inh_n   = inh_cnt;
    wd_n    = wd_cnt;
    dbit_n  = dbit_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    code_n  = code_q;
    wd_tick = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx.tx_valid && tx.tx_ready) begin
          data_n  = tx.tx_data;
          par_n   = ~^tx.tx_data;
          cnt_n   = '0;
          inh_n   = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_last) begin
          wd_n    = '0;
          state_n = REQ;
        end else begin
          inh_n = inh_cnt + 1'b1;
        end
      end
      REQ: begin
        if (fall) begin
          cnt_n   = 4'd1;
          dbit_n  = ~data_q[0];
          wd_n    = '0;
          state_n = DATA;
        end else begin
          wd_tick = 1'b1;
        end
      end
      DATA: begin
        if (fall) begin
          wd_n  = '0;
          cnt_n = bit_cnt + 1'b1;
          unique case (1'b1)
            (bit_cnt < 4'd8): dbit_n = ~data_q[bit_cnt[2:0]];
            (bit_cnt == 4'd8): dbit_n = ~par_q;
            (bit_cnt == 4'd9): dbit_n = 1'b0;
            default: begin
              // Eleventh edge: device ACK must hold DATA low.
              if (data_s) begin
                err_n   = 1'b1;
                code_n  = 2'b10;
                state_n = IDLE;
              end else begin
                state_n = ACK_WAIT;
              end
            end
          endcase
        end else begin
          wd_tick = 1'b1;
        end
      end
      ACK_WAIT: begin
        if (clk_s && data_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          wd_n = '0;
        end else begin
          wd_tick = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (wd_tick) begin
      if (wd_hit) begin
        err_n   = 1'b1;
        code_n  = 2'b01;
        state_n = IDLE;
      end else begin
        wd_n = wd_cnt + 1'b1;
      end
    end
  end

  assign tx.tx_ready = (state == IDLE) && !done_q && !err_q;
  assign tx.busy     = (state != IDLE);
  assign tx.done     = done_q;
  assign tx.err      = err_q;
  assign tx.err_code = code_q;

  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = (state == INHIBIT && inh_last)
                     || (state == REQ)
                     || (state == DATA && dbit_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
// Build with or without PS2_TX_GLITCH_FILTER_EN.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 200;
  localparam int H   = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line, data_line;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [10:0] dev_frame;

  typedef struct {
    logic        is_done;
    logic [1:0]  code;
    logic        chk_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t exp_q[$];

  ps2_host_tx_if bus();

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx(bus.slave),
    .ps2_clk_i(clk_line),
    .ps2_data_i(data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic d, input logic [1:0] c,
                      input logic cf, input logic [10:0] f);
    exp_t e;
    e.is_done = d;
    e.code = c;
    e.chk_frame = cf;
    e.frame = f;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    chk("tx_ready_pre", bus.tx_ready, 1);
    bus.tx_valid = 1'b1;
    bus.tx_data = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Device side: clocks 11 pulses, samples DATA at end of each low phase.
  task automatic dev_xfer(input bit nack, input int glitch_k,
                          input int rst_k);
    int t;
    t = 0;
    dev_frame = '1;
    while (!ps2_clk_oe && t < 3000) begin @(posedge clk); t++; end
    while (ps2_clk_oe && t < 3000) begin @(posedge clk); t++; end
    chk("dev_sees_request", (t < 3000), 1);
    if (t >= 3000) return;
    repeat (5) @(posedge clk);
    dev_frame[0] = data_line;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && !nack) dev_data_low = 1'b1;
      repeat (3) @(posedge clk);
      dev_clk_low = 1'b1;
      if (k == rst_k) begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_no_done", bus.done, 0);
        chk("rst_no_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        return;
      end
      repeat (H) @(posedge clk);
      if (k <= 10) dev_frame[k] = data_line;
      dev_clk_low = 1'b0;
      if (k == glitch_k) begin
        repeat (10) @(posedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(posedge clk);
        dev_clk_low = 1'b0;
        repeat (H - 13) @(posedge clk);
      end else begin
        repeat (H) @(posedge clk);
      end
    end
    repeat (5) @(posedge clk);
    dev_data_low = 1'b0;
  endtask

  // Monitor: pops an expectation for every done/err pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.done || bus.err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse done=%0b err=%0b exp=none",
                   bus.done, bus.err);
        end else begin
          e = exp_q.pop_front();
          chk("done_err_excl", bus.done & bus.err, 0);
          chk("done", bus.done, e.is_done);
          if (!e.is_done) chk("err_code", bus.err_code, e.code);
          chk("busy_at_pulse", bus.busy, 0);
          if (!e.is_done) begin
            chk("clk_oe_at_err", ps2_clk_oe, 0);
            chk("data_oe_at_err", ps2_data_oe, 0);
          end
          if (e.chk_frame) chk("frame", dev_frame, e.frame);
          @(negedge clk);
          chk("tx_ready_after", bus.tx_ready, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=hang exp=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n, c0, t;
    logic first_doe, last_doe;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx_ready", bus.tx_ready, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_err_code", bus.err_code, 0);
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_data_oe", ps2_data_oe, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED: start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; 0x00 ignored
    push(1'b1, 2'b00, 1'b1, 11'h7DA);
    fork
      dev_xfer(0, 0, 0);
      send(8'hED);
      begin
        repeat (300) @(negedge clk);
        chk("busy_mid", bus.busy, 1);
        chk("tx_ready_mid", bus.tx_ready, 0);
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'h00;
        @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    chk("no_second_xfer", ps2_clk_oe, 0);

    // 0xFF with NACK at the 11th clock
    push(1'b0, 2'b10, 1'b1, 11'h7FE);
    fork
      dev_xfer(1, 0, 0);
      send(8'hFF);
    join
    repeat (20) @(negedge clk);

    // 0xF4: 0,0,1,0,1,1,1,1, parity 0; err_code keeps 10
    push(1'b1, 2'b00, 1'b1, 11'h5E8);
    fork
      dev_xfer(0, 0, 0);
      send(8'hF4);
    join
    repeat (20) @(negedge clk);
    chk("err_code_held", bus.err_code, 2'b10);

    // Device never clocks: inhibit length, start bit, watchdog
    push(1'b0, 2'b01, 1'b0, 11'h000);
    send(8'h3C);
    t = 0;
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    n = 0;
    first_doe = ps2_data_oe;
    last_doe = 1'b0;
    while (ps2_clk_oe && t < 200) begin
      n++;
      last_doe = ps2_data_oe;
      @(negedge clk);
      t++;
    end
    chk("inhibit_len", n, INH);
    chk("inhibit_first_doe", first_doe, 0);
    chk("inhibit_last_doe", last_doe, 1);
    chk("req_start_bit", ps2_data_oe, 1);
    c0 = cyc;
    t = 0;
    while (!bus.err && t < 400) begin @(negedge clk); t++; end
    chk("timeout_latency", cyc - c0, TMO);
    repeat (5) @(negedge clk);

    // 3-cycle low glitch on PS2_CLK during bit 3
`ifdef PS2_TX_GLITCH_FILTER_EN
    push(1'b1, 2'b00, 1'b1, 11'h7DA);
`else
    push(1'b0, 2'b10, 1'b0, 11'h000);
`endif
    fork
      dev_xfer(0, 3, 0);
      send(8'hED);
    join
    repeat (20) @(negedge clk);

    // Reset asserted at bit 5
    fork
      dev_xfer(0, 0, 5);
      send(8'hF4);
    join
    repeat (30) @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_clk_oe", ps2_clk_oe, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
